// File: rtl/riscv_next_inject_buffer_if.sv
// Handshake bundle between the next-strategy injector/fetch stage (master)
// and the injection buffer (slave).
interface riscv_next_inject_buffer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  enable;
  logic                  i_stall;
  logic [ADDR_WIDTH-1:0] i_pm_pc;
  logic                  i_inject;
  logic [ADDR_WIDTH-1:0] i_inject_addr;
  logic                  i_flush;
  logic                  i_pred_ready;
  logic                  o_pred_valid;
  logic [ADDR_WIDTH-1:0] o_pred_addr;
  logic [ADDR_WIDTH-1:0] o_pred_src_pc;
  logic [CNT_W-1:0]      o_count;
  logic                  o_full;
  logic [15:0]           o_drop_cnt;

  modport master (
    output enable, i_stall, i_pm_pc, i_inject, i_inject_addr, i_flush, i_pred_ready,
    input  o_pred_valid, o_pred_addr, o_pred_src_pc, o_count, o_full, o_drop_cnt
  );

  modport slave (
    input  enable, i_stall, i_pm_pc, i_inject, i_inject_addr, i_flush, i_pred_ready,
    output o_pred_valid, o_pred_addr, o_pred_src_pc, o_count, o_full, o_drop_cnt
  );
endinterface

// File: rtl/riscv_next_inject_buffer.sv
// Circular FIFO of predicted {src_pc, target} injections feeding the fetch stage.
// Optional macro INJECT_BUFFER_DEDUP_EN suppresses pushes repeating the newest target.
module riscv_next_inject_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input logic                    clk,
  input logic                    reset,
  riscv_next_inject_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] src_mem_q  [DEPTH];

  logic pred_valid;
  logic full;
  logic flush;
  logic push_req;
  logic dup;
  logic room;
  logic push;
  logic pop;
  logic drop;

  assign pred_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign flush      = bus.enable && bus.i_flush;
  assign pop        = bus.enable && pred_valid && bus.i_pred_ready && !bus.i_flush;
  assign push_req   = bus.enable && bus.i_inject && !bus.i_stall && !bus.i_flush;

`ifdef INJECT_BUFFER_DEDUP_EN
  logic [PTR_W-1:0] last_ptr;
  assign last_ptr = wr_ptr_q - PTR_W'(1);
  assign dup      = pred_valid && (bus.i_inject_addr == addr_mem_q[last_ptr]);
`else
  assign dup      = 1'b0;
`endif

  // A full buffer still has room when the head leaves in the same cycle.
  assign room = !full || pop;
  assign push = push_req && !dup && room;
  assign drop = push_req && !dup && !room;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately unreset; an empty buffer never exposes it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.i_inject_addr;
      src_mem_q[wr_ptr_q]  <= bus.i_pm_pc;
    end
  end

  assign bus.o_pred_valid  = pred_valid;
  assign bus.o_pred_addr   = pred_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign bus.o_pred_src_pc = pred_valid ? src_mem_q[rd_ptr_q] : '0;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full;
  assign bus.o_drop_cnt    = drop_cnt_q;
endmodule
